// File: rtl/button_irq_source_if.sv
// Push-button interrupt bundle: raw key and ack in, irq level and status out.
// master is the interrupt producer, slave the consuming CPU side.
interface button_irq_source_if;
  logic       button_n;
  logic       irq_ack;
  logic       irq;
  logic       missed;
  logic       button_level;
  logic [7:0] press_count;

  modport master (
    input  button_n,
    input  irq_ack,
    output irq,
    output missed,
    output button_level,
    output press_count
  );

  modport slave (
    output button_n,
    output irq_ack,
    input  irq,
    input  missed,
    input  button_level,
    input  press_count
  );
endinterface

// File: rtl/button_irq_source.sv
// Alarm-clock key interrupt source: sync, debounce, press detect,
// pending irq with ack, sticky missed flag and press counter.
module button_irq_source #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input logic clk_clk,
  input logic reset_reset,
  button_irq_source_if.master bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             missed;
  logic [7:0]       count;
  logic             press;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.button_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (sync2 != stable) begin
      if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // stable_q lags stable so press marks the 1->0 edge only
  assign press = stable_q & ~stable;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stable_q <= 1'b1;
      level    <= 1'b0;
    end else begin
      stable_q <= stable;
      level    <= ~stable;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (press) state_nxt = PENDING;
      PENDING: if (!press && bus.irq_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // a press that collides with an ack is absorbed, not reported
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      missed <= 1'b0;
    end else if (press && state == PENDING) begin
      if (!bus.irq_ack) missed <= 1'b1;
    end else if (bus.irq_ack) begin
      missed <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      count <= 8'h00;
    end else if (press) begin
      count <= count + 8'd1;
    end
  end

  assign bus.irq          = (state == PENDING);
  assign bus.missed       = missed;
  assign bus.button_level = level;
  assign bus.press_count  = count;

endmodule

// File: tb/tb_button_irq_source.sv
// Directed bench for button_irq_source with a short debounce window.
// Table of held-input steps plus hand sequences for wrap and reset.
module tb_button_irq_source;

  localparam int DEB = 4;

  logic clk_clk = 1'b0;
  logic reset_reset = 1'b1;

  button_irq_source_if bus ();

  button_irq_source #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .bus        (bus)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic       btn;
    logic       ack;
    int         n;
    logic       irq;
    logic       missed;
    logic       lvl;
    logic [7:0] cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int passes = 0;
  int total  = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic irq,
                       input logic missed, input logic lvl,
                       input logic [7:0] cnt);
    total++;
    if (bus.irq === irq && bus.missed === missed &&
        bus.button_level === lvl && bus.press_count === cnt)
      passes++;
    else
      $display("FAIL %s: got irq=%b missed=%b level=%b count=%0d, want irq=%b missed=%b level=%b count=%0d",
               name, bus.irq, bus.missed, bus.button_level,
               bus.press_count, irq, missed, lvl, cnt);
  endtask

  task automatic add(input logic btn, input logic ack, input int n,
                     input logic irq, input logic missed,
                     input logic lvl, input logic [7:0] cnt,
                     input string name);
    vec_t v;
    v.btn = btn; v.ack = ack; v.n = n;
    v.irq = irq; v.missed = missed; v.lvl = lvl; v.cnt = cnt;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic press_release();
    bus.button_n = 1'b0;
    tick(DEB + 3);
    bus.button_n = 1'b1;
    tick(DEB + 4);
  endtask

  initial begin
    bus.button_n = 1'b1;
    bus.irq_ack  = 1'b0;

    add(1, 0, 0, 0, 0, 0, 8'd0, "reset_state");
    for (int i = 1; i <= 6; i++)
      add(0, 0, 1, 0, 0, 0, 8'd0, $sformatf("hold_edge%0d", i));
    add(0, 0, 1, 1, 0, 1, 8'd1, "irq_edge7");
    add(0, 1, 1, 0, 0, 1, 8'd1, "ack_clears");
    add(0, 0, 1, 0, 0, 1, 8'd1, "ack_idle_after");
    add(1, 0, 8, 0, 0, 0, 8'd1, "release_no_event");
    add(0, 0, 6, 0, 0, 0, 8'd1, "press2_wait");
    add(0, 0, 1, 1, 0, 1, 8'd2, "press2_irq");
    add(1, 0, 8, 1, 0, 0, 8'd2, "release2_pending");
    add(0, 0, 7, 1, 1, 1, 8'd3, "missed_set");
    add(0, 1, 1, 0, 0, 1, 8'd3, "ack_clears_missed");
    add(1, 0, 8, 0, 0, 0, 8'd3, "release3");
    add(0, 0, 7, 1, 0, 1, 8'd4, "press4_irq");
    add(1, 0, 8, 1, 0, 0, 8'd4, "release4_pending");
    add(0, 0, 6, 1, 0, 0, 8'd4, "press5_wait");
    add(0, 1, 1, 1, 0, 1, 8'd5, "press_ack_same");
    add(0, 0, 1, 1, 0, 1, 8'd5, "press_ack_hold");
    add(0, 1, 1, 0, 0, 1, 8'd5, "ack5");
    add(1, 0, 8, 0, 0, 0, 8'd5, "release5");
    for (int i = 0; i < 5; i++) begin
      add(0, 0, 3, 0, 0, 0, 8'd5, $sformatf("glitch_low%0d", i));
      add(1, 0, 3, 0, 0, 0, 8'd5, $sformatf("glitch_high%0d", i));
    end
    add(1, 0, 8, 0, 0, 0, 8'd5, "glitch_settle");

    tick(2);
    reset_reset = 1'b0;

    foreach (vecs[i]) begin
      bus.button_n = vecs[i].btn;
      bus.irq_ack  = vecs[i].ack;
      tick(vecs[i].n);
      check(vecs[i].name, vecs[i].irq, vecs[i].missed,
            vecs[i].lvl, vecs[i].cnt);
    end
    bus.irq_ack = 1'b0;

    reset_reset = 1'b1;
    tick(1);
    reset_reset = 1'b0;
    check("wrap_reset0", 0, 0, 0, 8'd0);
    for (int i = 0; i < 255; i++) press_release();
    check("wrap_255", 1, 1, 0, 8'd255);
    press_release();
    check("wrap_256", 1, 1, 0, 8'd0);

    bus.button_n = 1'b0;
    tick(3);
    #2;
    reset_reset = 1'b1;
    #1;
    check("async_reset", 0, 0, 0, 8'd0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check($sformatf("held_reset_edge%0d", i), 0, 0, 0, 8'd0);
    end
    tick(1);
    check("held_reset_irq", 1, 0, 1, 8'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/button_irq_source.md
Name: button_irq_source

Overview:
- Hardware source for the alarm-clock push-button interrupt: synchronises and debounces the raw active-low key, detects presses, and raises a level interrupt toward the Nios II.
- Holds the interrupt until software acknowledges it, and counts presses.
- Sits between the board key pin and the interrupt-button input of the processor system. It is the producing end of the interrupt line the CPU consumes.

Parameters:
- DEBOUNCE_CYCLES, 50000, stable-sample count required to accept a level change (1 ms at 50 MHz); legal range 2..65535.
- CNT_W, 16, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk_clk  input  1  system clock; all logic on rising edge.
- reset_reset  input  1  asynchronous, active-high reset.
- button_n  input  1  raw key, active-low (0 = pressed), asynchronous to clk_clk.
- irq_ack  input  1  one-cycle acknowledge pulse from software; clears the pending interrupt.
- irq  output  1  level interrupt request, high while a press is pending.
- missed  output  1  sticky flag: a press occurred while irq was already high.
- button_level  output  1  debounced key state, active-high (1 = pressed).
- press_count  output  8  debounced press counter, wraps.

Behaviour:
- Reset (async assert, sync release) values:
  - sync flops = 1; stable = 1 (released); debounce counter = 0.
  - irq = 0, missed = 0, button_level = 0, press_count = 0.
- Synchroniser:
  - Two-flop chain on button_n; sync2 is the synchronised sample.
  - No other logic samples button_n directly.
- Debounce:
  - Each cycle with sync2 != stable: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync2 != stable on that edge: stable <= sync2, counter <= 0.
  - Any cycle with sync2 == stable: counter <= 0. A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - button_level = ~stable, registered, so it follows stable by 1 cycle.
- Press detect:
  - press = registered falling edge of stable (1->0). It is a one-cycle pulse, 1 cycle after stable changes.
  - Release (0->1) produces no event.
- Latency from button_n low, held:
  - sync2 low after 2 edges.
  - stable low after DEBOUNCE_CYCLES further edges.
  - press and irq high after 1 further edge.
  - Total: irq rises on edge DEBOUNCE_CYCLES+3 after button_n is first sampled low.
- irq state machine, two states:
  - IDLE (irq=0) -> PENDING on press.
  - PENDING (irq=1) -> IDLE on irq_ack.
  - irq_ack in IDLE: ignored.
  - press and irq_ack in the same cycle while PENDING: set wins, stay PENDING, missed unchanged.
- missed:
  - Set on press while PENDING without a same-cycle ack.
  - Cleared by irq_ack; set beats clear.
- press_count:
  - Increments by 1 on every press regardless of irq state.
  - 8'hFF -> 8'h00 wraps silently.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A key held through reset release is accepted as a new press after DEBOUNCE_CYCLES+3 edges, because stable restarts at released.

Test Plan:
1. DEBOUNCE_CYCLES=4:
   - Stimulus: release reset, drive button_n=0 and hold.
   - Required: irq=0 through edge 6, irq=1 and press_count=1 on edge 7, button_level=1.
2. Glitch rejection:
   - Stimulus: button_n low for 3 cycles, then high, repeated 5 times.
   - Required: irq stays 0, press_count stays 0, button_level stays 0.
3. Acknowledge:
   - Stimulus: after scenario 1, pulse irq_ack.
   - Required: irq=0 next edge. Release then press again gives irq=1, press_count=2.
4. Missed press:
   - Stimulus: two debounced presses with no ack between.
   - Required: irq=1, missed=1, press_count=2. One irq_ack clears both irq and missed.
5. Simultaneous press and ack:
   - Stimulus: align the irq_ack pulse with the press pulse while PENDING.
   - Required: irq stays 1, missed stays 0.
6. Wrap and reset:
   - Stimulus: 256 presses, then assert reset_reset mid-debounce of press 257.
   - Required: press_count reads 8'h00 after 256 presses. Reset forces irq=0, missed=0, press_count=0 asynchronously (before the next clock edge).
